// File: rtl/io_pad_ccff_bank.sv
// io_pad_ccff_bank: multi-channel pad configuration memory.
// A serial CCFF chain (ccff_head -> ccff_tail) is loaded by shifting. A separate
// active bank copies the chain only on a synchronised CFG_DONE rise, so the pads
// never see a half-shifted configuration. Until the first commit, each
// channel's fabric-to-SOC output is held at its configured default bit.
module io_pad_ccff_bank #(
    parameter int   NUM_CH    = 4,
    parameter int   CFG_BITS  = 4,
    parameter logic DEF_RESET = 1'b0,
    parameter int   CNT_W     = 8
) (
    input  logic                         prog_clock,
    input  logic                         prog_reset_n,
    input  logic                         config_enable,
    input  logic                         CFG_DONE,
    input  logic                         ccff_head,
    output logic                         ccff_tail,
    output logic [NUM_CH*CFG_BITS-1:0]   mem_out,
    output logic [NUM_CH*CFG_BITS-1:0]   mem_outb,
    input  logic [NUM_CH-1:0]            pad_outpad,
    output logic [NUM_CH-1:0]            gfpga_pad_F2A,
    output logic                         cfg_loaded,
    output logic                         cfg_len_ok
);

    localparam int               L       = NUM_CH * CFG_BITS;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(L);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [L-1:0]     chain_q, chain_d;
    logic [L-1:0]     bank_q, bank_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             restart_q, restart_d;
    logic             loaded_q, loaded_d;
    logic             sync_q, sync_qq;
    logic             done_rise;

    // Two-flop synchroniser for the asynchronous CFG_DONE level.
    always_ff @(posedge prog_clock or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            sync_q  <= 1'b0;
            sync_qq <= 1'b0;
        end else begin
            // NOTE: non-blocking so sync_qq takes the old sync_q, giving two real stages.
            sync_q  <= CFG_DONE;
            sync_qq <= sync_q;
        end
    end

    // Only rising edges of CFG_DONE request a commit; falling edges are ignored.
    assign done_rise = sync_q & ~sync_qq;

    // Next-state logic for the chain, the bit counter and the commit FSM.
    always_comb begin
        // NOTE: every output gets a hold default first so no latch is inferred.
        state_d   = state_q;
        chain_d   = chain_q;
        bank_d    = bank_q;
        cnt_d     = cnt_q;
        restart_d = restart_q;
        loaded_d  = loaded_q;

        // The counter restarts on the first shift after a commit, and that shift
        // itself counts as bit one so a full reload reads exactly L. A shift
        // landing in the COMMIT cycle is likewise the first of the next reload.
        if (config_enable) begin
            chain_d   = {chain_q[L-2:0], ccff_head};
            restart_d = 1'b0;
            if (restart_q || state_q == COMMIT) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (state_q == COMMIT) begin
            restart_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (done_rise) begin
                    state_d = config_enable ? PENDING : COMMIT;
                end
            end
            PENDING: begin
                // Further rises here are absorbed: one commit per pending request.
                if (!config_enable) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // chain_q is the pre-shift value even if shifting restarts now.
                bank_d   = chain_q;
                loaded_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // All chain, bank, counter and FSM state registers.
    always_ff @(posedge prog_clock or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q   <= IDLE;
            chain_q   <= '0;
            bank_q    <= {L{DEF_RESET}};
            cnt_q     <= '0;
            restart_q <= 1'b0;
            loaded_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            chain_q   <= chain_d;
            bank_q    <= bank_d;
            cnt_q     <= cnt_d;
            restart_q <= restart_d;
            loaded_q  <= loaded_d;
        end
    end

    assign ccff_tail  = chain_q[L-1];
    assign mem_out    = bank_q;
    assign mem_outb   = ~bank_q;
    assign cfg_loaded = loaded_q;
    assign cfg_len_ok = (cnt_q == CNT_LEN);

    // Before the first commit each pad drives its channel's lowest config bit.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_pad_gate
        assign gfpga_pad_F2A[c] = loaded_q ? pad_outpad[c] : bank_q[c*CFG_BITS];
    end

endmodule

// File: tb/tb_io_pad_ccff_bank.sv
// Directed bench for io_pad_ccff_bank with hand-computed expected values.
module tb_io_pad_ccff_bank;

    logic        prog_clock = 1'b0;
    logic        prog_reset_n;
    logic        config_enable;
    logic        cfg_done;
    logic        ccff_head;
    logic        ccff_tail;
    logic [15:0] mem_out;
    logic [15:0] mem_outb;
    logic [3:0]  pad_outpad;
    logic [3:0]  gfpga_pad_F2A;
    logic        cfg_loaded;
    logic        cfg_len_ok;

    int checks = 0;
    int errors = 0;

    logic [15:0] word_a;
    logic [15:0] word_b;
    logic [4:0]  tail_bits;

    io_pad_ccff_bank #(
        .NUM_CH(4), .CFG_BITS(4), .DEF_RESET(1'b0), .CNT_W(8)
    ) dut (
        .prog_clock    (prog_clock),
        .prog_reset_n  (prog_reset_n),
        .config_enable (config_enable),
        .CFG_DONE      (cfg_done),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .mem_out       (mem_out),
        .mem_outb      (mem_outb),
        .pad_outpad    (pad_outpad),
        .gfpga_pad_F2A (gfpga_pad_F2A),
        .cfg_loaded    (cfg_loaded),
        .cfg_len_ok    (cfg_len_ok)
    );

    always #5 prog_clock = ~prog_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge prog_clock);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        ccff_head     = b;
        config_enable = 1'b1;
        tick();
    endtask

    initial begin
        word_a    = 16'hA5C3;
        word_b    = 16'h3C5A;
        tail_bits = 5'b10110;

        // Reset state
        prog_reset_n  = 1'b0;
        config_enable = 1'b0;
        cfg_done      = 1'b0;
        ccff_head     = 1'b0;
        pad_outpad    = 4'hF;
        #3;
        check("rst_mem_out", mem_out, 16'h0000);
        check("rst_mem_outb", mem_outb, 16'hFFFF);
        check("rst_loaded", cfg_loaded, 1'b0);
        check("rst_gfpga", gfpga_pad_F2A, 4'h0);
        check("rst_tail", ccff_tail, 1'b0);
        check("rst_len_ok", cfg_len_ok, 1'b0);
        tick();
        tick();
        prog_reset_n = 1'b1;
        tick();

        // Load 0xA5C3 MSB first; tail stays 0 until the 16th edge
        for (int i = 15; i >= 1; i--) shift_bit(word_a[i]);
        check("tail_before_16", ccff_tail, 1'b0);
        shift_bit(word_a[0]);
        check("tail_after_16", ccff_tail, 1'b1);
        config_enable = 1'b0;
        tick();
        check("len_ok_16", cfg_len_ok, 1'b1);
        check("no_commit_yet", mem_out, 16'h0000);
        check("tail_hold", ccff_tail, 1'b1);

        // CFG_DONE rise commits on the third edge
        cfg_done = 1'b1;
        tick();
        tick();
        check("commit_edge2", mem_out, 16'h0000);
        tick();
        check("commit_edge3", mem_out, 16'hA5C3);
        check("commit_outb", mem_outb, 16'h5A3C);
        check("loaded", cfg_loaded, 1'b1);
        check("len_ok_status", cfg_len_ok, 1'b1);
        pad_outpad = 4'h6;
        #1;
        check("gfpga_mirror", gfpga_pad_F2A, 4'h6);

        // Falling CFG_DONE is ignored; reload 0x3C5A while the old stream exits
        cfg_done = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 15; i >= 0; i--) begin
            check("tail_stream", ccff_tail, word_a[i]);
            shift_bit(word_b[i]);
        end
        check("len_ok_reload", cfg_len_ok, 1'b1);
        check("bank_stable", mem_out, 16'hA5C3);

        // CFG_DONE rise while shifting: commit deferred until enable drops
        cfg_done = 1'b1;
        for (int i = 4; i >= 0; i--) shift_bit(tail_bits[i]);
        check("pending_no_update", mem_out, 16'hA5C3);
        check("len_ok_21", cfg_len_ok, 1'b0);
        config_enable = 1'b0;
        tick();
        tick();
        check("deferred_commit", mem_out, 16'h8B56);
        check("len_ok_21_hold", cfg_len_ok, 1'b0);

        // Async reset while PENDING discards the request
        cfg_done = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 0; i < 4; i++) shift_bit(1'b1);
        cfg_done = 1'b1;
        for (int i = 0; i < 3; i++) shift_bit(1'b1);
        pad_outpad = 4'hF;
        #2;
        prog_reset_n = 1'b0;
        #1;
        check("async_rst_mem", mem_out, 16'h0000);
        check("async_rst_loaded", cfg_loaded, 1'b0);
        check("async_rst_len", cfg_len_ok, 1'b0);
        check("async_rst_tail", ccff_tail, 1'b0);
        check("async_rst_gfpga", gfpga_pad_F2A, 4'h0);
        cfg_done      = 1'b0;
        config_enable = 1'b0;
        tick();
        prog_reset_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("no_commit_after_rst", mem_out, 16'h0000);
        check("still_unloaded", cfg_loaded, 1'b0);

        // 300 shifts: count passes 16 once, then saturates at 255 without wrapping
        for (int n = 1; n <= 300; n++) begin
            shift_bit(1'b1);
            if (n == 16)  check("sat_len_ok_16", cfg_len_ok, 1'b1);
            if (n == 272) check("sat_no_wrap_272", cfg_len_ok, 1'b0);
        end
        config_enable = 1'b0;
        tick();
        check("sat_len_ok_300", cfg_len_ok, 1'b0);
        check("sat_tail", ccff_tail, 1'b1);

        // Commit regardless of cfg_len_ok
        cfg_done = 1'b1;
        tick();
        tick();
        tick();
        check("commit_bad_len", mem_out, 16'hFFFF);
        check("commit_bad_len_loaded", cfg_loaded, 1'b1);
        pad_outpad = 4'h9;
        #1;
        check("gfpga_mirror2", gfpga_pad_F2A, 4'h9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
